// File: rtl/cq_viola_avm_pollmaster_pkg.sv
// Shared encodings for the Avalon-MM poll master: command ops, response status
// codes and the controller state type.
package cq_viola_avm_pollmaster_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_POLL = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT,
    S_GAP,
    S_RESP
  } state_e;

  // The reserved encoding behaves exactly like a read.
  function automatic op_e decode_op(input logic [1:0] raw);
    op_e op;
    op = op_e'(raw);
    if (op == OP_RSVD) op = OP_RD;
    return op;
  endfunction

  function automatic logic poll_match(input logic [31:0] data,
                                      input logic [31:0] cmp,
                                      input logic [31:0] mask);
    return (data & mask) == (cmp & mask);
  endfunction

endpackage

// File: rtl/cq_viola_avm_pollmaster.sv
// Single-command Avalon-MM initiator: write, read, or poll-until-match with a
// cycle timeout, driving chipselect/write_n style register slaves.
module cq_viola_avm_pollmaster
  import cq_viola_avm_pollmaster_pkg::*;
#(
  parameter int ADDR_W       = 2,
  parameter int READ_LATENCY = 1,
  parameter int POLL_GAP     = 4,
  parameter int TMO_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       cmd_writedata,
  input  logic [31:0]       cmd_mask,
  input  logic [TMO_W-1:0]  cmd_timeout,
  output logic              rsp_valid,
  output logic [31:0]       rsp_readdata,
  output logic [1:0]        rsp_status,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);
  localparam logic [7:0] GAP_LAST = 8'((POLL_GAP == 0) ? 0 : (POLL_GAP - 1));

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        mask_q, mask_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         lat_q, lat_d;
  logic [7:0]         gap_q, gap_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               cs_q, cs_d;
  logic               wrn_q, wrn_d;
  logic               ready_q, ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic [1:0]         rsp_status_q, rsp_status_d;

  logic               expired;
  logic               expired_next;
  logic               beat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_WR;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      tmo_q        <= '0;
      cnt_q        <= '0;
      lat_q        <= '0;
      gap_q        <= '0;
      rdata_q      <= '0;
      cs_q         <= 1'b0;
      wrn_q        <= 1'b1;
      ready_q      <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      gap_q        <= gap_d;
      rdata_q      <= rdata_d;
      cs_q         <= cs_d;
      wrn_q        <= wrn_d;
      ready_q      <= ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    tmo_d        = tmo_q;
    lat_d        = lat_q;
    gap_d        = gap_q;
    rdata_d      = rdata_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_status_d = rsp_status_q;

    cnt_d = cnt_q;
    if ((state_q inside {S_ISSUE, S_RDWAIT, S_GAP}) && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMO_W'(1);
    end

    expired = (tmo_q != '0) && (cnt_q >= tmo_q);
    beat    = cs_q && !avm_waitrequest;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = S_ISSUE;
          op_d    = decode_op(cmd_op);
          addr_d  = cmd_address;
          wdata_d = cmd_writedata;
          mask_d  = cmd_mask;
          tmo_d   = cmd_timeout;
          cnt_d   = '0;
          rdata_d = '0;
        end
      end

      S_ISSUE: begin
        if (expired) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = rdata_q;
          rsp_status_d = ST_TIMEOUT;
        end else if (beat) begin
          if (op_q == OP_WR) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = '0;
            rsp_status_d = ST_OK;
          end else begin
            state_d = S_RDWAIT;
            lat_d   = LAT_LAST;
          end
        end
      end

      // A read already on the bus always completes; only afterwards may the
      // timeout win, and a match beats a simultaneous timeout.
      S_RDWAIT: begin
        if (lat_q != 3'd0) begin
          lat_d = lat_q - 3'd1;
        end else begin
          rdata_d = avm_readdata;
          if ((op_q != OP_POLL) || poll_match(avm_readdata, wdata_q, mask_q)) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = avm_readdata;
            rsp_status_d = ST_OK;
          end else if (expired) begin
            state_d      = S_RESP;
            rsp_valid_d  = 1'b1;
            rsp_rdata_d  = avm_readdata;
            rsp_status_d = ST_TIMEOUT;
          end else if (POLL_GAP == 0) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LAST;
          end
        end
      end

      S_GAP: begin
        if (expired) begin
          state_d      = S_RESP;
          rsp_valid_d  = 1'b1;
          rsp_rdata_d  = rdata_q;
          rsp_status_d = ST_TIMEOUT;
        end else if (gap_q == 8'd0) begin
          state_d = S_ISSUE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Chipselect looks one cycle ahead so an ISSUE cycle that is already out
    // of budget never presents a beat to the slave.
    expired_next = (tmo_d != '0) && (cnt_d >= tmo_d);
    cs_d         = (state_d == S_ISSUE) && !expired_next;
    wrn_d        = !(cs_d && (op_d == OP_WR));
    ready_d      = (state_d == S_IDLE);
  end

  assign cmd_ready      = ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_readdata   = rsp_rdata_q;
  assign rsp_status     = rsp_status_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = wrn_q;
  assign avm_writedata  = wdata_q;

endmodule
